cache_tag_store: RTL and testbench

- Per-set tag/valid store and replacement controller for the set-associative cache model.
- Sits directly upstream of the tag-match block. Each cycle it drives that block with the indexed set's tag array and the request tag, then consumes the returned way index.
- It qualifies the returned way with its own valid bits and returns hit/miss, way and eviction information.
- On a miss it allocates a way (lowest invalid way first, else tree pseudo-LRU) and writes the new tag.

---
 rtl/cache_tag_store.sv | 246 ++++++++++++++++++++++++
 tb/tb_cache_tag_store.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_store.sv
// ---------------------------------------------------------------------------
// cache_tag_store
// Per-set tag/valid store and replacement controller for a set-associative
// cache model. A lookup takes three cycles: IDLE (accept), LOOKUP (drive the
// external tag-match block and qualify its answer), RESP (one-cycle response
// pulse, then array/PLRU update on the closing edge).
//
// Optional feature: define STATS_EN to add saturating hit/miss counters
// (stat_hits, stat_misses).
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   req_valid/req_ready request handshake; ready only in IDLE
//   req_addr            request address {tag, set, line offset}
//   sel_tag_array       tags of the captured set, to the tag-match block
//   sel_tag             captured request tag, to the tag-match block
//   sel_way             way returned by the tag-match block (untrusted)
//   rsp_valid           one-cycle response pulse
//   rsp_hit/rsp_way     hit flag and hit way (or allocated way on a miss)
//   rsp_set             set of the response
//   rsp_evict           miss replaced a valid line
//   rsp_evict_tag       tag of the replaced line, 0 when no eviction
//   stat_hits/misses    (STATS_EN only) saturating 32-bit counters
// ---------------------------------------------------------------------------
module cache_tag_store #(
  parameter  int unsigned i_size = 20,
  parameter  int unsigned c_size = 12,
  parameter  int unsigned a_size = 8,
  parameter  int unsigned d_size = 6,
  localparam int unsigned way_w  = $clog2(a_size),
  localparam int unsigned set_w  = c_size - d_size - way_w,
  localparam int unsigned tag_w  = i_size - set_w - d_size,
  localparam int unsigned n_sets = 1 << set_w,
  localparam int unsigned plru_w = a_size - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [i_size-1:0] req_addr,
  output logic [tag_w-1:0]  sel_tag_array [a_size],
  output logic [tag_w-1:0]  sel_tag,
  input  logic [way_w-1:0]  sel_way,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [way_w-1:0]  rsp_way,
  output logic [set_w-1:0]  rsp_set,
  output logic              rsp_evict,
  output logic [tag_w-1:0]  rsp_evict_tag
`ifdef STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Storage
  logic [tag_w-1:0]  r_tags  [n_sets][a_size];
  logic [a_size-1:0] r_valid [n_sets];
  logic [plru_w-1:0] r_plru  [n_sets];

  // Control and captured request
  state_t            r_state;
  logic              r_req_ready;
  logic [tag_w-1:0]  r_tag;
  logic [set_w-1:0]  r_set;
  logic [tag_w-1:0]  r_sel_tag_array [a_size];

  // Registered response
  logic              r_rsp_valid;
  logic              r_rsp_hit;
  logic [way_w-1:0]  r_rsp_way;
  logic [set_w-1:0]  r_rsp_set;
  logic              r_rsp_evict;
  logic [tag_w-1:0]  r_rsp_evict_tag;

`ifdef STATS_EN
  logic [31:0]       r_stat_hits;
  logic [31:0]       r_stat_misses;
`endif

  // Address slicing; line-offset bits are not needed by the tag store
  logic [tag_w-1:0]  w_req_tag;
  logic [set_w-1:0]  w_req_set;
  logic              w_unused_offset;

  assign w_req_tag       = req_addr[i_size-1 -: tag_w];
  assign w_req_set       = req_addr[d_size +: set_w];
  assign w_unused_offset = ^req_addr[d_size-1:0];

  // Walk the tree from the root following each node's bit to the victim leaf
  function automatic logic [way_w-1:0] plru_victim(input logic [plru_w-1:0] p);
    logic [way_w-1:0]  v;
    logic [plru_w-1:0] sh;
    logic              b;
    int unsigned       node;
    v    = '0;
    node = 0;
    for (int lvl = 0; lvl < int'(way_w); lvl++) begin
      sh   = p >> node;
      b    = sh[0];
      v    = (v << 1) | way_w'(b);
      node = 2 * node + 1 + 32'(b);
    end
    return v;
  endfunction

  // Point every node on the accessed way's path at the other half
  function automatic logic [plru_w-1:0] plru_touch(input logic [plru_w-1:0] p,
                                                   input logic [way_w-1:0]  way);
    logic [plru_w-1:0] q;
    logic [way_w-1:0]  w;
    logic              b;
    int unsigned       node;
    q    = p;
    w    = way;
    node = 0;
    for (int lvl = 0; lvl < int'(way_w); lvl++) begin
      b    = w[way_w-1];
      w    = w << 1;
      q    = (q & ~(plru_w'(1) << node)) | (plru_w'(!b) << node);
      node = 2 * node + 1 + 32'(b);
    end
    return q;
  endfunction

  // Lookup qualification against the captured set
  logic [a_size-1:0] w_set_valid;
  logic [plru_w-1:0] w_set_plru;
  logic              w_hit;
  logic [way_w-1:0]  w_victim;
  logic [way_w-1:0]  w_way;
  logic              w_evict;
  logic [tag_w-1:0]  w_evict_tag;
  logic [plru_w-1:0] w_plru_next;

  assign w_set_valid = r_valid[r_set];
  assign w_set_plru  = r_plru[r_set];

  // The returned way is only a hint: it must be valid and really match
  assign w_hit = w_set_valid[sel_way] && (r_tags[r_set][sel_way] == r_tag);

  // Lowest invalid way wins; PLRU only when the set is full
  always_comb begin
    logic [a_size-1:0] sh;
    w_victim = plru_victim(w_set_plru);
    sh       = '0;
    for (int i = int'(a_size) - 1; i >= 0; i--) begin
      sh = w_set_valid >> i;
      if (!sh[0]) w_victim = way_w'(i);
    end
  end

  assign w_way       = w_hit ? sel_way : w_victim;
  assign w_evict     = !w_hit && w_set_valid[w_victim];
  assign w_evict_tag = w_evict ? r_tags[r_set][w_victim] : '0;
  assign w_plru_next = plru_touch(w_set_plru, r_rsp_way);

  // Main FSM, storage and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_req_ready     <= 1'b0;
      r_tag           <= '0;
      r_set           <= '0;
      r_sel_tag_array <= '{default: '0};
      r_rsp_valid     <= 1'b0;
      r_rsp_hit       <= 1'b0;
      r_rsp_way       <= '0;
      r_rsp_set       <= '0;
      r_rsp_evict     <= 1'b0;
      r_rsp_evict_tag <= '0;
      r_tags          <= '{default: '{default: '0}};
      r_valid         <= '{default: '0};
      r_plru          <= '{default: '0};
`ifdef STATS_EN
      r_stat_hits     <= '0;
      r_stat_misses   <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (r_req_ready && req_valid) begin
            r_tag           <= w_req_tag;
            r_set           <= w_req_set;
            r_sel_tag_array <= r_tags[w_req_set];
            r_req_ready     <= 1'b0;
            r_state         <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_rsp_valid     <= 1'b1;
          r_rsp_hit       <= w_hit;
          r_rsp_way       <= w_way;
          r_rsp_set       <= r_set;
          r_rsp_evict     <= w_evict;
          r_rsp_evict_tag <= w_evict_tag;
          r_state         <= S_RESP;
        end
        S_RESP: begin
          if (!r_rsp_hit) begin
            r_tags[r_set][r_rsp_way]  <= r_tag;
            r_valid[r_set][r_rsp_way] <= 1'b1;
          end
          r_plru[r_set] <= w_plru_next;
`ifdef STATS_EN
          if (r_rsp_hit) begin
            if (r_stat_hits != 32'hFFFF_FFFF) r_stat_hits <= r_stat_hits + 32'd1;
          end else begin
            if (r_stat_misses != 32'hFFFF_FFFF) r_stat_misses <= r_stat_misses + 32'd1;
          end
`endif
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_req_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign sel_tag_array = r_sel_tag_array;
  assign sel_tag       = r_tag;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_hit       = r_rsp_hit;
  assign rsp_way       = r_rsp_way;
  assign rsp_set       = r_rsp_set;
  assign rsp_evict     = r_rsp_evict;
  assign rsp_evict_tag = r_rsp_evict_tag;
`ifdef STATS_EN
  assign stat_hits     = r_stat_hits;
  assign stat_misses   = r_stat_misses;
`endif

endmodule

// File: tb/tb_cache_tag_store.sv
// Directed bench for cache_tag_store at default parameters
// (set = addr[8:6], tag = addr[19:9], 8 ways).
module tb_cache_tag_store;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_addr;
  logic [10:0] sel_tag_array [8];
  logic [10:0] sel_tag;
  logic [2:0]  sel_way;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [2:0]  rsp_way;
  logic [2:0]  rsp_set;
  logic        rsp_evict;
  logic [10:0] rsp_evict_tag;
`ifdef STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int total = 0;
  int bad   = 0;

  cache_tag_store dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .sel_tag_array (sel_tag_array),
    .sel_tag       (sel_tag),
    .sel_way       (sel_way),
    .rsp_valid     (rsp_valid),
    .rsp_hit       (rsp_hit),
    .rsp_way       (rsp_way),
    .rsp_set       (rsp_set),
    .rsp_evict     (rsp_evict),
    .rsp_evict_tag (rsp_evict_tag)
`ifdef STATS_EN
    ,
    .stat_hits     (stat_hits),
    .stat_misses   (stat_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag-match model: lowest way whose stored tag equals the request tag,
  // ignoring valid bits (so stale tags can produce a false way)
  always_comb begin
    sel_way = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (sel_tag_array[i] == sel_tag) sel_way = 3'(i);
  end

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(req_ready), 64'd1);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready",     64'(req_ready),     64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid),     64'd0);
    chk("rst_rsp_hit",   64'(rsp_hit),       64'd0);
    chk("rst_rsp_way",   64'(rsp_way),       64'd0);
    chk("rst_rsp_set",   64'(rsp_set),       64'd0);
    chk("rst_evict",     64'(rsp_evict),     64'd0);
    chk("rst_evict_tag", 64'(rsp_evict_tag), 64'd0);
    chk("rst_sel_tag",   64'(sel_tag),       64'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One request, checked in LOOKUP, RESP and the cycle after
  task automatic request(input string nm, input logic [19:0] addr,
                         input logic exp_hit, input logic [2:0] exp_way,
                         input logic [2:0] exp_set, input logic exp_ev,
                         input logic [10:0] exp_evtag);
    logic [10:0] exp_tag;
    exp_tag = addr[19:9];
    wait_ready();
    req_addr  = addr;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lookup_valid"}, 64'(rsp_valid), 64'd0);
    chk({nm, "_lookup_ready"}, 64'(req_ready), 64'd0);
    chk({nm, "_sel_tag"},      64'(sel_tag),   64'(exp_tag));
    @(negedge clk);
    chk({nm, "_valid"},     64'(rsp_valid),     64'd1);
    chk({nm, "_ready"},     64'(req_ready),     64'd0);
    chk({nm, "_hit"},       64'(rsp_hit),       64'(exp_hit));
    chk({nm, "_way"},       64'(rsp_way),       64'(exp_way));
    chk({nm, "_set"},       64'(rsp_set),       64'(exp_set));
    chk({nm, "_evict"},     64'(rsp_evict),     64'(exp_ev));
    chk({nm, "_evict_tag"}, 64'(rsp_evict_tag), 64'(exp_evtag));
    @(negedge clk);
    chk({nm, "_pulse_end"}, 64'(rsp_valid), 64'd0);
    chk({nm, "_way_hold"},  64'(rsp_way),   64'(exp_way));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;

    // Stale tag 0 matches way 0 but is invalid -> miss
    do_reset();
    request("zero", 20'h00000, 1'b0, 3'd0, 3'd0, 1'b0, 11'h000);

    // Miss then hit on 0x12345 (tag 0x091, set 5)
    do_reset();
    request("a_miss", 20'h12345, 1'b0, 3'd0, 3'd5, 1'b0, 11'h000);
    chk("a_tag_091", 64'(sel_tag), 64'h091);
    request("a_hit",  20'h12345, 1'b1, 3'd0, 3'd5, 1'b0, 11'h000);

    // Fill set 5 in way order, then evict via PLRU
    do_reset();
    for (int t = 1; t <= 8; t++)
      request($sformatf("fill%0d", t), 20'((t << 9) | (5 << 6)),
              1'b0, 3'(t - 1), 3'd5, 1'b0, 11'h000);
    request("evict9", 20'((9 << 9) | (5 << 6)), 1'b0, 3'd0, 3'd5, 1'b1, 11'h001);
    request("hit2",   20'((2 << 9) | (5 << 6)), 1'b1, 3'd1, 3'd5, 1'b0, 11'h000);

    // Continuous req_valid: accepted exactly every third cycle
    do_reset();
    wait_ready();
    req_addr  = 20'h12345;
    req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("stream_ready%0d", i), 64'(req_ready), 64'((i % 3) == 0));
      chk($sformatf("stream_valid%0d", i), 64'(rsp_valid), 64'((i % 3) == 2));
      if (i < 8) @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);

    // Reset in LOOKUP discards the request
    do_reset();
    wait_ready();
    req_addr  = 20'h12345;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_lookup_tag", 64'(sel_tag), 64'h091);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_valid_rst", 64'(rsp_valid), 64'd0);
    chk("abort_ready_rst", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort_no_rsp%0d", i), 64'(rsp_valid), 64'd0);
    end
    request("abort_rereq", 20'h12345, 1'b0, 3'd0, 3'd5, 1'b0, 11'h000);

`ifdef STATS_EN
    do_reset();
    chk("stat_rst_hits",   64'(stat_hits),   64'd0);
    chk("stat_rst_misses", 64'(stat_misses), 64'd0);
    request("s_m1", 20'h12345, 1'b0, 3'd0, 3'd5, 1'b0, 11'h000);
    request("s_m2", 20'h00040, 1'b0, 3'd0, 3'd1, 1'b0, 11'h000);
    request("s_m3", 20'h00080, 1'b0, 3'd0, 3'd2, 1'b0, 11'h000);
    request("s_h1", 20'h12345, 1'b1, 3'd0, 3'd5, 1'b0, 11'h000);
    request("s_h2", 20'h00040, 1'b1, 3'd0, 3'd1, 1'b0, 11'h000);
    chk("stat_hits",   64'(stat_hits),   64'd2);
    chk("stat_misses", 64'(stat_misses), 64'd3);
    force dut.r_stat_hits = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_stat_hits;
    request("s_h3", 20'h00080, 1'b1, 3'd0, 3'd2, 1'b0, 11'h000);
    chk("stat_hits_sat",     64'(stat_hits),   64'hFFFF_FFFF);
    chk("stat_misses_after", 64'(stat_misses), 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
